// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at a time; rvalid answers the most recent gnt.
interface instruction_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the RV32IF core: owns the PC, issues single-outstanding imem
// fetches and holds the fetched word in the IF/ID register.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                              clk,
   input  logic                              rst,
   instruction_fetch_unit_if.master          imem,
   input  logic                              jump,
   input  logic [31:0]                       jump_address,
   input  logic                              ex_redirect,
   input  logic [31:0]                       ex_target,
   input  logic                              id_stall,
   output logic                              if_valid,
   output logic [31:0]                       if_pc,
   output logic [31:0]                       if_instr
);

   localparam int unsigned XLEN       = 32;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              kill_q, kill_d;
   logic              valid_d;
   logic [XLEN-1:0]   if_pc_d;
   logic [XLEN-1:0]   instr_d;

   assign imem.imem_req  = (state_q == S_REQ) & ~rst;
   assign imem.imem_addr = pc_q & ALIGN_MASK;

   // Next-state logic; an EX redirect wins over JAL and normal handoff.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      kill_d  = kill_q;
      valid_d = if_valid;
      if_pc_d = if_pc;
      instr_d = if_instr;

      if (ex_redirect) begin
         pc_d    = ex_target & ALIGN_MASK;
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
         case (state_q)
            S_REQ: begin
               // A request granted this cycle is already in flight; mark it stale.
               if (imem.imem_gnt) begin
                  state_d = S_WAIT;
                  kill_d  = 1'b1;
               end
            end
            S_WAIT: begin
               if (imem.imem_rvalid) begin
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem.imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem.imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     state_d = S_HOLD;
                     instr_d = imem.imem_rdata;
                     if_pc_d = pc_q;
                     valid_d = 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (!id_stall) begin
                  pc_d    = (jump && if_valid) ? (jump_address & ALIGN_MASK)
                                               : (if_pc + XLEN'(4));
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC & ALIGN_MASK;
         kill_q   <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_instr <= NOP_INSTR;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         kill_q   <= kill_d;
         if_valid <= valid_d;
         if_pc    <= if_pc_d;
         if_instr <= instr_d;
      end
   end

endmodule
